// File: rtl/aes_key_expander_if.sv
// Control and round-key output bundle of the AES key expander.
// out_valid/out_ready: a beat moves on any rising edge where both are high; while out_valid is
// high and out_ready is low the producer holds out_rk/out_index/out_last unchanged.
interface aes_key_expander_if;
    logic         start;
    logic [1:0]   nk;
    logic [255:0] key;
    logic         busy;
    logic         done;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_rk;
    logic [3:0]   out_index;
    logic         out_last;
    logic [1:0]   state;

    modport master (
        output start, nk, key, out_ready,
        input  busy, done, out_valid, out_rk, out_index, out_last, state
    );
    modport slave (
        input  start, nk, key, out_ready,
        output busy, done, out_valid, out_rk, out_index, out_last, state
    );
endinterface

// File: rtl/aes_key_expander.sv
// FIPS-197 key expansion for AES-128/192/256, one 32-bit word per cycle,
// round keys delivered as 128-bit beats over a valid/ready port.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // Byte 0 of the table sits in the top bits, so byte a starts at bit 8*(255-a) = {~a,000}.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign y = SBOX[{~a, 3'b000} +: 8];
endmodule

module aes_key_expander (
    input  logic               clk,
    input  logic               rst_n,
    aes_key_expander_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2} state_t;

    state_t       state;
    logic [255:0] key_q;
    logic [1:0]   nk_q;
    logic [31:0]  hist [8];
    logic [31:0]  stage [3];
    logic [5:0]   i;
    logic [2:0]   kpos;
    logic [7:0]   rcon;

    logic [2:0]   nk_last;
    logic [5:0]   w_total;
    logic [31:0]  w_far;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic [31:0]  t;
    logic [31:0]  w_new;
    logic         past_key;
    logic         rot_step;
    logic         sub_step;
    logic         stall;
    logic         produce;
    logic         xfer;

    always_comb begin
        nk_last = 3'd7;
        w_total = 6'd60;
        w_far   = hist[7];
        case (nk_q)
            2'b00: begin nk_last = 3'd3; w_total = 6'd44; w_far = hist[3]; end
            2'b01: begin nk_last = 3'd5; w_total = 6'd52; w_far = hist[5]; end
            default: ;
        endcase
    end

    // kpos tracks i mod Nk so no divider is needed.
    assign past_key = (i > {3'b000, nk_last});
    assign rot_step = past_key && (kpos == 3'd0);
    assign sub_step = past_key && nk_q[1] && (kpos == 3'd4);
    assign sub_in   = rot_step ? {hist[0][23:0], hist[0][31:24]} : hist[0];

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .y(sub_out[8*b +: 8]));
    end

    assign t       = rot_step ? (sub_out ^ {rcon, 24'h000000}) :
                     sub_step ? sub_out : hist[0];
    assign w_new   = past_key ? (w_far ^ t) : key_q[255:224];

    // The word that completes a beat may not overwrite a beat still waiting on out_ready.
    assign xfer    = bus.out_valid && bus.out_ready;
    assign stall   = bus.out_valid && !bus.out_ready && (i[1:0] == 2'b11);
    assign produce = (state == EXPAND) && (i < w_total) && !stall;

    assign bus.state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            key_q         <= '0;
            nk_q          <= '0;
            i             <= '0;
            kpos          <= '0;
            rcon          <= 8'h01;
            for (int k = 0; k < 8; k++) hist[k] <= '0;
            for (int k = 0; k < 3; k++) stage[k] <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_rk    <= '0;
            bus.out_index <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        key_q    <= bus.key;
                        nk_q     <= bus.nk;
                        i        <= '0;
                        kpos     <= '0;
                        rcon     <= 8'h01;
                        bus.busy <= 1'b1;
                        state    <= EXPAND;
                    end
                end
                EXPAND: begin
                    if (xfer) begin
                        bus.out_valid <= 1'b0;
                        if (bus.out_last) begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end
                    end
                    if (produce) begin
                        hist[0] <= w_new;
                        for (int k = 1; k < 8; k++) hist[k] <= hist[k-1];
                        key_q <= key_q << 32;
                        i     <= i + 6'd1;
                        kpos  <= (kpos == nk_last) ? 3'd0 : kpos + 3'd1;
                        if (rot_step) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                        case (i[1:0])
                            2'b00: stage[0] <= w_new;
                            2'b01: stage[1] <= w_new;
                            2'b10: stage[2] <= w_new;
                            default: begin
                                bus.out_rk    <= {stage[0], stage[1], stage[2], w_new};
                                bus.out_index <= i[5:2];
                                bus.out_last  <= (i == w_total - 6'd1);
                                bus.out_valid <= 1'b1;
                            end
                        endcase
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: FIPS-197 vectors, random keys and back-pressure,
// restart and reset-abort, checked against an array-based KeyExpansion model.
module tb_aes_key_expander;
    localparam int W = 133;
    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    aes_key_expander_if bus();
    aes_key_expander dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int last_cyc = 0;
    int xfer_count = 0;
    logic rdy_mode = 1'b0;
    logic tmode = 1'b1;
    logic expect_done = 1'b0;
    logic stall_prev = 1'b0;
    logic [W-1:0] held;
    logic [W-1:0] exp_q[$];
    logic [127:0] got_rk [16];
    logic         got_last [16];
    logic [7:0] sbox_tab [256];
    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            sbox_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
    endfunction

    function automatic void push_expected(input logic [255:0] k, input logic [1:0] n);
        int nkw;
        int nr;
        logic [31:0] w [60];
        logic [31:0] t;
        nkw = (n == 2'b00) ? 4 : ((n == 2'b01) ? 6 : 8);
        nr  = nkw + 6;
        for (int i = 0; i < nkw; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = nkw; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nkw == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_tab[i/nkw - 1], 24'h0};
            else if (nkw == 8 && i % 8 == 4) t = sub_word(t);
            w[i] = w[i-nkw] ^ t;
        end
        for (int j = 0; j <= nr; j++)
            exp_q.push_back({(j == nr), 4'(j), w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]});
    endfunction

    task automatic run_key(input logic [255:0] k, input logic [1:0] n);
        push_expected(k, n);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.key   = k;
        bus.nk    = n;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        accept_cyc = cyc;
        bus.key    = {$urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), $urandom()};
        bus.nk     = 2'($urandom_range(0, 3));
        @(negedge clk);
        check("busy_after_start", bus.busy, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (!bus.busy && !bus.done && exp_q.size() == 0 && !expect_done) break;
        end
        if (n == budget) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic wait_beats(input int count, input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (xfer_count >= count) break;
        end
        if (n == budget) begin
            checks++;
            errors++;
            $display("FAIL wait_beats: saw %0d beats, required %0d", xfer_count, count);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_flags"}, {bus.busy, bus.done, bus.out_valid, bus.out_last}, 0);
        check({tag, "_rk"}, bus.out_rk, 0);
        check({tag, "_index"}, bus.out_index, 0);
        check({tag, "_state"}, bus.state, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.out_ready = (rdy_mode && $urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every transferred beat.
    initial begin
        logic [W-1:0] cur;
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            cur = {bus.out_last, bus.out_index, bus.out_rk};
            if (!rst_n) begin
                exp_q.delete();
                xfer_count  = 0;
                expect_done = 1'b0;
                stall_prev  = 1'b0;
            end else begin
                if (expect_done) begin
                    check("done_pulse", {bus.done, bus.busy}, 2'b10);
                    expect_done = 1'b0;
                end else if (bus.done) begin
                    check("done_unexpected", bus.done, 0);
                end
                if (stall_prev) begin
                    check("stall_valid", bus.out_valid, 1);
                    check("stall_hold", cur, held);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL beat_unexpected: got %0h required no beat", cur);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", cur, e);
                    end
                    if (tmode)
                        check("beat_cycle", cyc, (xfer_count == 0) ? accept_cyc + 4 : last_cyc + 4);
                    last_cyc = cyc;
                    got_rk[bus.out_index]   = bus.out_rk;
                    got_last[bus.out_index] = bus.out_last;
                    if (bus.out_last) begin
                        expect_done = 1'b1;
                        xfer_count  = 0;
                    end else begin
                        xfer_count++;
                    end
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                held = cur;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] rk;
        logic [1:0] rn;
        build_sbox();
        bus.start = 1'b0;
        bus.nk    = 2'b00;
        bus.key   = '0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // AES-128 known answer, full-rate timing
        wait_idle(50);
        run_key(K128, 2'b00);
        wait_idle(200);
        check("t1_j1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("t1_j10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("t1_last", got_last[10], 1);

        run_key(K192, 2'b01);
        wait_idle(200);
        check("t2_j12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);

        run_key(K256, 2'b10);
        wait_idle(200);
        check("t3_j14_nk10", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
        run_key(K256, 2'b11);
        wait_idle(200);
        check("t3_j14_nk11", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

        // Back-pressure
        rdy_mode = 1'b1;
        tmode    = 1'b0;
        run_key(K128, 2'b00);
        wait_idle(1000);
        check("t4_j10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Start while busy is ignored; back-to-back start after done
        rdy_mode = 1'b0;
        tmode    = 1'b1;
        run_key(K128, 2'b00);
        wait_beats(3, 100);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.key   = K256;
        bus.nk    = 2'b10;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("t5_busy_kept", bus.busy, 1);
        wait_idle(200);
        run_key(K128, 2'b00);
        wait_idle(200);

        for (int r = 0; r < 8; r++) begin
            rk = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            rn = 2'($urandom_range(0, 3));
            rdy_mode = 1'($urandom_range(0, 1));
            tmode    = !rdy_mode;
            run_key(rk, rn);
            wait_idle(1000);
        end

        // Reset mid-expansion, then a fresh AES-128 run
        rdy_mode = 1'b0;
        tmode    = 1'b1;
        run_key(K256, 2'b10);
        wait_beats(5, 100);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("t6_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_no_beat", bus.out_valid, 0);
        run_key(K128, 2'b00);
        wait_idle(200);
        check("t6_j1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("t6_j10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
